// File: rtl/instruction_memory_loader.sv
// Instruction memory with a byte-serial boot loader in front of the fetch stage.
// After reset the core is held in reset while a length-prefixed, big-endian
// program stream is assembled into 32-bit words and written into the array.
// Once the declared number of words has arrived, the core is released and
// instructions are served combinationally from the core's PC.
module instruction_memory_loader #(
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  load_byte,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] PC,
  output logic [31:0] current_instruction,
  output logic        processor_reset,
  output logic        load_done,
  output logic        load_error
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  // Word counts are compared at 17 bits so a full 65536-word array still fits.
  localparam logic [16:0] DEPTH_WIDE = 17'(DEPTH);

  typedef enum logic [2:0] {
    COUNT_HI,
    COUNT_LO,
    DATA,
    RUN,
    ERROR
  } loader_state_t;

  loader_state_t state;

  logic [15:0]              word_count;
  logic [ADDRESS_WIDTH:0]   word_address;
  logic [1:0]               byte_index;
  logic [23:0]              word_shift;
  logic [31:0]              mem [DEPTH];

  logic                     byte_accepted;
  logic [15:0]              next_count;
  logic [31:0]              assembled_word;
  logic                     word_complete;
  logic [16:0]              words_written;
  logic                     mem_write;

  logic [ADDRESS_WIDTH-1:0] read_index;
  logic                     read_in_range;
  logic                     pc_offset_unused;

  // Status outputs are decoded straight from the state register.
  assign load_ready      = (state == COUNT_HI) || (state == COUNT_LO) || (state == DATA);
  assign processor_reset = (state != RUN);
  assign load_done       = (state == RUN);
  assign load_error      = (state == ERROR);

  assign byte_accepted  = load_valid && load_ready;
  assign next_count     = {word_count[15:8], load_byte};
  assign assembled_word = {word_shift, load_byte};
  assign word_complete  = (state == DATA) && byte_accepted && (byte_index == 2'd3);
  assign words_written  = 17'(word_address) + 17'd1;
  assign mem_write      = word_complete;

  // Loader sequencing: length prefix, then big-endian words until the count is reached.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= COUNT_HI;
      word_count   <= 16'h0000;
      word_address <= '0;
      byte_index   <= 2'd0;
      word_shift   <= 24'h000000;
    end else begin
      case (state)
        COUNT_HI: begin
          if (byte_accepted) begin
            word_count[15:8] <= load_byte;
            state            <= COUNT_LO;
          end
        end
        COUNT_LO: begin
          if (byte_accepted) begin
            word_count   <= next_count;
            word_address <= '0;
            byte_index   <= 2'd0;
            if (next_count == 16'h0000) begin
              state <= RUN;
            end else if ({1'b0, next_count} > DEPTH_WIDE) begin
              state <= ERROR;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (byte_accepted) begin
            if (byte_index == 2'd3) begin
              word_address <= word_address + 1'b1;
              byte_index   <= 2'd0;
              word_shift   <= 24'h000000;
              if (words_written == {1'b0, word_count}) begin
                state <= RUN;
              end
            end else begin
              word_shift <= {word_shift[15:0], load_byte};
              byte_index <= byte_index + 2'd1;
            end
          end
        end
        RUN: begin
          state <= RUN;
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state <= ERROR;
        end
      endcase
    end
  end

  // Array write port; contents deliberately survive reset, reads are gated by word_count.
  always_ff @(posedge clock) begin
    if (mem_write) begin
      mem[word_address[ADDRESS_WIDTH-1:0]] <= assembled_word;
    end
  end

  assign read_index       = PC[ADDRESS_WIDTH+1:2];
  assign pc_offset_unused = ^PC[1:0];

  // Fetch path: only loaded words are visible, everything else reads as a NOP.
  always_comb begin
    read_in_range       = (PC[31:ADDRESS_WIDTH+2] == '0) &&
                          (17'(read_index) < {1'b0, word_count});
    current_instruction = 32'h0000_0000;
    if ((state == RUN) && read_in_range) begin
      current_instruction = mem[read_index];
    end
  end

endmodule

// File: doc/instruction_memory_loader.md
Name: instruction_memory_loader

Overview:
Instruction memory for the processor core, with a built-in byte-serial boot loader that sits directly upstream of the fetch stage. After reset it holds the core in reset and receives a length-prefixed program stream. It assembles the stream into 32-bit words and writes them into an internal word array. Once the program is loaded, it releases the core and serves `current_instruction` combinationally from the core's `PC`.

Parameters:
- ADDRESS_WIDTH, 10, word-address width; DEPTH = 2**ADDRESS_WIDTH words.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (reset==0 at a posedge resets the block).
- load_byte  input  8  boot stream byte.
- load_valid  input  1  load_byte valid this cycle.
- load_ready  output  1  block accepts a byte this cycle; transfer occurs when load_valid && load_ready at posedge.
- PC  input  32  byte address from the core's fetch stage.
- current_instruction  output  32  instruction word at PC, combinational.
- processor_reset  output  1  active-high reset to the core.
- load_done  output  1  program loaded, core running.
- load_error  output  1  declared program length exceeds DEPTH.

Behaviour:
- States: COUNT_HI, COUNT_LO, DATA, RUN, ERROR.
- Reset values: state COUNT_HI, word_count 0, word_address 0, byte_index 0, processor_reset 1, load_done 0, load_error 0. Memory array is NOT cleared.
- load_ready = 1 in COUNT_HI, COUNT_LO and DATA; 0 in RUN and ERROR. Bytes presented while load_ready==0 are ignored.
- COUNT_HI: an accepted byte sets word_count[15:8] -> COUNT_LO.
- COUNT_LO: an accepted byte sets word_count[7:0]. Next state is decided on the full 16-bit count:
  - count==0 -> RUN;
  - count>DEPTH -> ERROR;
  - otherwise -> DATA.
- DATA: words arrive big-endian; byte_index 0 -> bits 31:24, 1 -> 23:16, 2 -> 15:8, 3 -> 7:0.
  - On the edge accepting byte_index 3: write the assembled word to mem[word_address], increment word_address, clear byte_index.
  - If that write is the word_count-th word, move to RUN on the same edge.
- Gaps in load_valid are allowed anywhere. A partial word is held indefinitely; there is no timeout.
- RUN: processor_reset=0 and load_done=1, both combinational from state. They therefore change in the first cycle after the edge that accepted the final byte. RUN persists until reset.
- ERROR: load_error=1, processor_reset=1, load_done=0, load_ready=0. ERROR persists until reset.
- Read path, all combinational:
  - current_instruction = mem[PC[ADDRESS_WIDTH+1:2]] only if state==RUN, PC[31:ADDRESS_WIDTH+2]==0, and word index < word_count.
  - Otherwise current_instruction = 32'h0 (sll r0,r0,0 = NOP).
  - PC[1:0] are ignored.
- Write and read never conflict: the array is written only outside RUN and read only in RUN.
- Reset mid-load: returns to COUNT_HI and discards the partial word and count. Stale array contents are unreachable because the new word_count gates reads.
- Arithmetic: word_count is 16 bits. The count>DEPTH comparison is done at 17 bits, so DEPTH=65536 is handled. word_address is ADDRESS_WIDTH+1 bits so reaching DEPTH does not wrap.

Test Plan:
- Basic load: stream 00 02 24 01 00 05 00 21 10 20 -> load_ready 0, load_done 1 and processor_reset 0 in the cycle after the 10th byte is accepted. Then PC=0 -> 0x24010005, PC=4 -> 0x00211020, PC=8 -> 0x00000000.
- Empty program: stream 00 00 -> RUN after the 2nd byte; PC=0 -> 0x00000000; load_done 1.
- Oversize count: with ADDRESS_WIDTH=10, stream 04 01 -> load_error 1, load_ready 0, processor_reset stays 1. A following byte 0x24 is ignored and load_error remains 1.
- Throttled stream: the basic-load stream with load_valid low for 3 cycles between every byte -> identical memory contents. processor_reset stays 1 until the final byte is accepted, and load_valid after RUN has no effect.
- Reset mid-load: reset low for 1 cycle after 5 bytes of the basic stream, then stream 00 01 AA BB CC DD -> PC=0 -> 0xAABBCCDD, PC=4 -> 0x00000000.
- Address edge cases after the basic load: PC=1 and PC=3 -> 0x24010005; PC=0x00001000 -> 0x00000000. During loading, PC=0 -> 0x00000000.
